// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite channel bundle used for both requester ports and the shared slave port.
// "master" is the side that issues addresses/data, "slave" the side that answers.
interface axi_lite_arbiter_if;
  logic [31:0] ARdata;
  logic [2:0]  ARprot;
  logic        ARvalid;
  logic        ARready;
  logic [31:0] Rdata;
  logic        Rvalid;
  logic        Rready;
  logic [31:0] AWdata;
  logic [2:0]  AWprot;
  logic        AWvalid;
  logic        AWready;
  logic [31:0] Wdata;
  logic [3:0]  Wstrb;
  logic        Wvalid;
  logic        Wready;
  logic        Bvalid;
  logic        Bready;

  modport master (
    output ARdata, ARprot, ARvalid, input ARready,
    input  Rdata, Rvalid, output Rready,
    output AWdata, AWprot, AWvalid, input AWready,
    output Wdata, Wstrb, Wvalid, input Wready,
    input  Bvalid, output Bready
  );

  modport slave (
    input  ARdata, ARprot, ARvalid, output ARready,
    output Rdata, Rvalid, input Rready,
    input  AWdata, AWprot, AWvalid, output AWready,
    input  Wdata, Wstrb, Wvalid, output Wready,
    output Bvalid, input Bready
  );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter. Reads and writes are arbitrated
// independently with round-robin priority and one outstanding transaction per
// direction. Payload passes straight through once a grant is held.
module axi_lite_arbiter (
  input  logic                    clk,
  input  logic                    rst,
  axi_lite_arbiter_if.slave       m0_if,
  axi_lite_arbiter_if.slave       m1_if,
  axi_lite_arbiter_if.master      s_if
);
  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rdState_e;
  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_RESP} wrState_e;

  rdState_e rdState_q;
  logic     rdGrant_q;
  logic     rdPrio_q;
  wrState_e wrState_q;
  logic     wrGrant_q;
  logic     wrPrio_q;
  logic     awDone_q;
  logic     wDone_q;

  // Granted master's view of each channel (selected by the held grant)
  logic [31:0] gArData, gAwData, gWData;
  logic [2:0]  gArProt, gAwProt;
  logic [3:0]  gWStrb;
  logic        gArValid, gRReady, gAwValid, gWValid, gBReady;

  assign gArData  = rdGrant_q ? m1_if.ARdata  : m0_if.ARdata;
  assign gArProt  = rdGrant_q ? m1_if.ARprot  : m0_if.ARprot;
  assign gArValid = rdGrant_q ? m1_if.ARvalid : m0_if.ARvalid;
  assign gRReady  = rdGrant_q ? m1_if.Rready  : m0_if.Rready;
  assign gAwData  = wrGrant_q ? m1_if.AWdata  : m0_if.AWdata;
  assign gAwProt  = wrGrant_q ? m1_if.AWprot  : m0_if.AWprot;
  assign gAwValid = wrGrant_q ? m1_if.AWvalid : m0_if.AWvalid;
  assign gWData   = wrGrant_q ? m1_if.Wdata   : m0_if.Wdata;
  assign gWStrb   = wrGrant_q ? m1_if.Wstrb   : m0_if.Wstrb;
  assign gWValid  = wrGrant_q ? m1_if.Wvalid  : m0_if.Wvalid;
  assign gBReady  = wrGrant_q ? m1_if.Bready  : m0_if.Bready;

  // Phase decodes; a channel whose handshake already happened is closed off
  logic rdAddr, rdData, rdBusy, wrAddr, wrResp, wrBusy, awOpen, wOpen;
  assign rdAddr = (rdState_q == RD_ADDR);
  assign rdData = (rdState_q == RD_DATA);
  assign rdBusy = (rdState_q != RD_IDLE);
  assign wrAddr = (wrState_q == WR_ADDR);
  assign wrResp = (wrState_q == WR_RESP);
  assign wrBusy = (wrState_q != WR_IDLE);
  assign awOpen = wrAddr & ~awDone_q;
  assign wOpen  = wrAddr & ~wDone_q;

  // Channel-level ready/valid toward the slave and toward the granted master
  logic sArValid, sRReady, sAwValid, sWValid, sBReady;
  logic arReadyG, rValidG, awReadyG, wReadyG, bValidG;
  assign sArValid = rdAddr & gArValid;
  assign sRReady  = rdData & gRReady;
  assign sAwValid = awOpen & gAwValid;
  assign sWValid  = wOpen & gWValid;
  assign sBReady  = wrResp & gBReady;
  assign arReadyG = rdAddr & s_if.ARready;
  assign rValidG  = rdData & s_if.Rvalid;
  assign awReadyG = awOpen & s_if.AWready;
  assign wReadyG  = wOpen & s_if.Wready;
  assign bValidG  = wrResp & s_if.Bvalid;

  logic arHs, rHs, awHs, wHs, bHs;
  assign arHs = sArValid & s_if.ARready;
  assign rHs  = rValidG & sRReady;
  assign awHs = sAwValid & s_if.AWready;
  assign wHs  = sWValid & s_if.Wready;
  assign bHs  = bValidG & sBReady;

  // Slave-side outputs; payload is zero whenever the direction is idle
  assign s_if.ARdata  = rdBusy ? gArData : 32'h0;
  assign s_if.ARprot  = rdBusy ? gArProt : 3'h0;
  assign s_if.ARvalid = sArValid;
  assign s_if.Rready  = sRReady;
  assign s_if.AWdata  = wrBusy ? gAwData : 32'h0;
  assign s_if.AWprot  = wrBusy ? gAwProt : 3'h0;
  assign s_if.AWvalid = sAwValid;
  assign s_if.Wdata   = wrBusy ? gWData : 32'h0;
  assign s_if.Wstrb   = wrBusy ? gWStrb : 4'h0;
  assign s_if.Wvalid  = sWValid;
  assign s_if.Bready  = sBReady;

  // Master-side outputs; only the granted master ever sees ready/valid
  assign m0_if.ARready = arReadyG & ~rdGrant_q;
  assign m1_if.ARready = arReadyG &  rdGrant_q;
  assign m0_if.Rvalid  = rValidG  & ~rdGrant_q;
  assign m1_if.Rvalid  = rValidG  &  rdGrant_q;
  assign m0_if.Rdata   = s_if.Rdata;
  assign m1_if.Rdata   = s_if.Rdata;
  assign m0_if.AWready = awReadyG & ~wrGrant_q;
  assign m1_if.AWready = awReadyG &  wrGrant_q;
  assign m0_if.Wready  = wReadyG  & ~wrGrant_q;
  assign m1_if.Wready  = wReadyG  &  wrGrant_q;
  assign m0_if.Bvalid  = bValidG  & ~wrGrant_q;
  assign m1_if.Bvalid  = bValidG  &  wrGrant_q;

  // Read arbiter: grant on request, hold through AR and R, then hand priority over
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdState_q <= RD_IDLE;
      rdGrant_q <= 1'b0;
      rdPrio_q  <= 1'b0;
    end else begin
      case (rdState_q)
        RD_IDLE: begin
          if (m0_if.ARvalid | m1_if.ARvalid) begin
            rdGrant_q <= (m0_if.ARvalid & m1_if.ARvalid) ? rdPrio_q : m1_if.ARvalid;
            rdState_q <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (arHs) rdState_q <= RD_DATA;
        end
        RD_DATA: begin
          if (rHs) begin
            rdState_q <= RD_IDLE;
            rdPrio_q  <= ~rdGrant_q;
          end
        end
        default: rdState_q <= RD_IDLE;
      endcase
    end
  end

  // Write arbiter: AW and W complete in any order, then wait for the B response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrState_q <= WR_IDLE;
      wrGrant_q <= 1'b0;
      wrPrio_q  <= 1'b0;
      awDone_q  <= 1'b0;
      wDone_q   <= 1'b0;
    end else begin
      case (wrState_q)
        WR_IDLE: begin
          if (m0_if.AWvalid | m1_if.AWvalid) begin
            wrGrant_q <= (m0_if.AWvalid & m1_if.AWvalid) ? wrPrio_q : m1_if.AWvalid;
            wrState_q <= WR_ADDR;
          end
        end
        WR_ADDR: begin
          awDone_q <= awDone_q | awHs;
          wDone_q  <= wDone_q | wHs;
          if ((awDone_q | awHs) & (wDone_q | wHs)) wrState_q <= WR_RESP;
        end
        WR_RESP: begin
          if (bHs) begin
            wrState_q <= WR_IDLE;
            wrPrio_q  <= ~wrGrant_q;
            awDone_q  <= 1'b0;
            wDone_q   <= 1'b0;
          end
        end
        default: wrState_q <= WR_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Self-checking bench for axi_lite_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of who owns each direction and which phase it is in.
module tb_axi_lite_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;

  // Free-running clock, period 10
  always #5 clk = ~clk;

  axi_lite_arbiter_if m0Bus();
  axi_lite_arbiter_if m1Bus();
  axi_lite_arbiter_if sBus();

  axi_lite_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .m0_if (m0Bus),
    .m1_if (m1Bus),
    .s_if  (sBus)
  );

  logic [31:0] mArData [2];
  logic [2:0]  mArProt [2];
  logic [31:0] mAwData [2];
  logic [2:0]  mAwProt [2];
  logic [31:0] mWData  [2];
  logic [3:0]  mWStrb  [2];
  logic [1:0]  mArValid, mRReady, mAwValid, mWValid, mBReady;
  logic        sArReady, sRValid, sAwReady, sWReady, sBValid;
  logic [31:0] sRData;

  assign m0Bus.ARdata  = mArData[0];
  assign m0Bus.ARprot  = mArProt[0];
  assign m0Bus.ARvalid = mArValid[0];
  assign m0Bus.Rready  = mRReady[0];
  assign m0Bus.AWdata  = mAwData[0];
  assign m0Bus.AWprot  = mAwProt[0];
  assign m0Bus.AWvalid = mAwValid[0];
  assign m0Bus.Wdata   = mWData[0];
  assign m0Bus.Wstrb   = mWStrb[0];
  assign m0Bus.Wvalid  = mWValid[0];
  assign m0Bus.Bready  = mBReady[0];
  assign m1Bus.ARdata  = mArData[1];
  assign m1Bus.ARprot  = mArProt[1];
  assign m1Bus.ARvalid = mArValid[1];
  assign m1Bus.Rready  = mRReady[1];
  assign m1Bus.AWdata  = mAwData[1];
  assign m1Bus.AWprot  = mAwProt[1];
  assign m1Bus.AWvalid = mAwValid[1];
  assign m1Bus.Wdata   = mWData[1];
  assign m1Bus.Wstrb   = mWStrb[1];
  assign m1Bus.Wvalid  = mWValid[1];
  assign m1Bus.Bready  = mBReady[1];
  assign sBus.ARready  = sArReady;
  assign sBus.Rdata    = sRData;
  assign sBus.Rvalid   = sRValid;
  assign sBus.AWready  = sAwReady;
  assign sBus.Wready   = sWReady;
  assign sBus.Bvalid   = sBValid;

  wire [1:0]  oArReady = {m1Bus.ARready, m0Bus.ARready};
  wire [1:0]  oRValid  = {m1Bus.Rvalid,  m0Bus.Rvalid};
  wire [1:0]  oAwReady = {m1Bus.AWready, m0Bus.AWready};
  wire [1:0]  oWReady  = {m1Bus.Wready,  m0Bus.Wready};
  wire [1:0]  oBValid  = {m1Bus.Bvalid,  m0Bus.Bvalid};
  wire [31:0] oRData0  = m0Bus.Rdata;
  wire [31:0] oRData1  = m1Bus.Rdata;

  int vectors = 0;
  int miscompares = 0;

  // Model: owner of each direction (-1 = free), its phase, and the preferred master
  int rdOwner, rdPref, wrOwner, wrPref;
  bit rdDataPh, wrRespPh, awSeen, wSeen;
  int rdDone = 0;
  int wrDone = 0;

  logic [1:0] seenAr, seenAw, seenW;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] toOwner(input logic v, input int o);
    return (o == 1) ? {v, 1'b0} : {1'b0, v};
  endfunction

  task automatic modelReset();
    rdOwner = -1; rdPref = 0; rdDataPh = 1'b0;
    wrOwner = -1; wrPref = 0; wrRespPh = 1'b0; awSeen = 1'b0; wSeen = 1'b0;
  endtask

  task automatic idleInputs();
    for (int i = 0; i < 2; i++) begin
      mArData[i] = 32'h0; mArProt[i] = 3'h0;
      mAwData[i] = 32'h0; mAwProt[i] = 3'h0;
      mWData[i]  = 32'h0; mWStrb[i]  = 4'h0;
    end
    mArValid = 2'b00; mRReady = 2'b00; mAwValid = 2'b00; mWValid = 2'b00; mBReady = 2'b00;
    sArReady = 1'b0; sRValid = 1'b0; sAwReady = 1'b0; sWReady = 1'b0; sBValid = 1'b0;
    sRData = 32'h0;
  endtask

  // Compare every DUT output against what the model says it must be right now
  task automatic checkOutput();
    int ro, wo;
    logic rAddr, rData, wAddr, wResp, rOwned, wOwned;
    ro = (rdOwner < 0) ? 0 : rdOwner;
    wo = (wrOwner < 0) ? 0 : wrOwner;
    rOwned = (rdOwner >= 0);
    wOwned = (wrOwner >= 0);
    rAddr = rOwned && !rdDataPh;
    rData = rOwned && rdDataPh;
    wAddr = wOwned && !wrRespPh;
    wResp = wOwned && wrRespPh;
    chk("s_ARvalid", 32'(sBus.ARvalid), 32'(rAddr & mArValid[ro]));
    chk("s_ARdata",  sBus.ARdata, rOwned ? mArData[ro] : 32'h0);
    chk("s_ARprot",  32'(sBus.ARprot), 32'(rOwned ? mArProt[ro] : 3'h0));
    chk("m_ARready", 32'(oArReady), 32'(rAddr ? toOwner(sArReady, ro) : 2'b00));
    chk("m_Rvalid",  32'(oRValid),  32'(rData ? toOwner(sRValid, ro) : 2'b00));
    chk("s_Rready",  32'(sBus.Rready), 32'(rData & mRReady[ro]));
    chk("m0_Rdata",  oRData0, sRData);
    chk("m1_Rdata",  oRData1, sRData);
    chk("s_AWvalid", 32'(sBus.AWvalid), 32'(wAddr & !awSeen & mAwValid[wo]));
    chk("s_AWdata",  sBus.AWdata, wOwned ? mAwData[wo] : 32'h0);
    chk("s_AWprot",  32'(sBus.AWprot), 32'(wOwned ? mAwProt[wo] : 3'h0));
    chk("m_AWready", 32'(oAwReady), 32'((wAddr & !awSeen) ? toOwner(sAwReady, wo) : 2'b00));
    chk("s_Wvalid",  32'(sBus.Wvalid), 32'(wAddr & !wSeen & mWValid[wo]));
    chk("s_Wdata",   sBus.Wdata, wOwned ? mWData[wo] : 32'h0);
    chk("s_Wstrb",   32'(sBus.Wstrb), 32'(wOwned ? mWStrb[wo] : 4'h0));
    chk("m_Wready",  32'(oWReady), 32'((wAddr & !wSeen) ? toOwner(sWReady, wo) : 2'b00));
    chk("m_Bvalid",  32'(oBValid), 32'(wResp ? toOwner(sBValid, wo) : 2'b00));
    chk("s_Bready",  32'(sBus.Bready), 32'(wResp & mBReady[wo]));
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic modelStep();
    bit awNow, wNow;
    if (rdOwner < 0) begin
      rdDataPh = 1'b0;
      if (mArValid == 2'b11) rdOwner = rdPref;
      else if (mArValid[0]) rdOwner = 0;
      else if (mArValid[1]) rdOwner = 1;
    end else if (!rdDataPh) begin
      if (mArValid[rdOwner] && sArReady) rdDataPh = 1'b1;
    end else if (sRValid && mRReady[rdOwner]) begin
      rdPref = 1 - rdOwner;
      rdOwner = -1;
      rdDataPh = 1'b0;
      rdDone++;
    end
    if (wrOwner < 0) begin
      awSeen = 1'b0; wSeen = 1'b0; wrRespPh = 1'b0;
      if (mAwValid == 2'b11) wrOwner = wrPref;
      else if (mAwValid[0]) wrOwner = 0;
      else if (mAwValid[1]) wrOwner = 1;
    end else if (!wrRespPh) begin
      awNow = awSeen || (mAwValid[wrOwner] && sAwReady);
      wNow  = wSeen  || (mWValid[wrOwner] && sWReady);
      awSeen = awNow;
      wSeen  = wNow;
      if (awNow && wNow) wrRespPh = 1'b1;
    end else if (sBValid && mBReady[wrOwner]) begin
      wrPref = 1 - wrOwner;
      wrOwner = -1;
      wrDone++;
    end
  endtask

  task automatic evalCycle();
    @(negedge clk);
    checkOutput();
    seenAr = mArValid & oArReady;
    seenAw = mAwValid & oAwReady;
    seenW  = mWValid & oWReady;
    modelStep();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    idleInputs();
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput();
    chk("rst_s_ARvalid", 32'(sBus.ARvalid), 32'd0);
    chk("rst_s_AWdata",  sBus.AWdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One read with the given requesters; expM is the master that must win
  task automatic applyStimulusRead(input logic [1:0] mask, input int expM,
                                   input logic [31:0] base, input logic [31:0] rdVal);
    for (int i = 0; i < 2; i++) begin
      if (mask[i]) begin
        mArValid[i] = 1'b1;
        mArData[i]  = base + 32'(i) * 32'h100;
        mArProt[i]  = 3'(i + 1);
      end
    end
    sArReady = 1'b1;
    evalCycle();
    chk("rd_idle_no_arvalid", 32'(sBus.ARvalid), 32'd0);
    advance();
    evalCycle();
    chk("rd_grant_arvalid", 32'(sBus.ARvalid), 32'd1);
    chk("rd_grant_addr", sBus.ARdata, base + 32'(expM) * 32'h100);
    chk("rd_grant_ready", 32'(oArReady), 32'(toOwner(1'b1, expM)));
    advance();
    mArValid = 2'b00; sArReady = 1'b0;
    sRValid = 1'b1; sRData = rdVal; mRReady = 2'b11;
    evalCycle();
    chk("rd_rvalid", 32'(oRValid), 32'(toOwner(1'b1, expM)));
    chk("rd_rdata", (expM == 1) ? oRData1 : oRData0, rdVal);
    advance();
    idleInputs();
  endtask

  task automatic applyStimulusRandom();
    for (int i = 0; i < 2; i++) begin
      if (seenAr[i]) mArValid[i] = 1'b0;
      else if (!mArValid[i] && $urandom_range(0, 3) == 0) begin
        mArValid[i] = 1'b1; mArData[i] = $urandom; mArProt[i] = 3'($urandom);
      end
      if (seenAw[i]) mAwValid[i] = 1'b0;
      else if (!mAwValid[i] && $urandom_range(0, 3) == 0) begin
        mAwValid[i] = 1'b1; mAwData[i] = $urandom; mAwProt[i] = 3'($urandom);
      end
      if (seenW[i]) mWValid[i] = 1'b0;
      else if (!mWValid[i] && $urandom_range(0, 3) == 0) begin
        mWValid[i] = 1'b1; mWData[i] = $urandom; mWStrb[i] = 4'($urandom);
      end
      mRReady[i] = ($urandom_range(0, 3) != 0);
      mBReady[i] = ($urandom_range(0, 3) != 0);
    end
    sArReady = 1'($urandom_range(0, 1));
    sRValid  = 1'($urandom_range(0, 1));
    sRData   = $urandom;
    sAwReady = 1'($urandom_range(0, 1));
    sWReady  = 1'($urandom_range(0, 1));
    sBValid  = 1'($urandom_range(0, 1));
  endtask

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: directed scenarios, then randomized traffic
  initial begin
    int rdStart, wrStart;
    modelReset();
    idleInputs();
    seenAr = 2'b00; seenAw = 2'b00; seenW = 2'b00;
    #2;
    applyReset();

    applyStimulusRead(2'b01, 0, 32'h0000_1000, 32'hDEAD_BEEF);
    chk("model_rdPref_after_m0", 32'(rdPref), 32'd1);
    applyStimulusRead(2'b11, 1, 32'h0000_2000, 32'h1111_0001);

    applyReset();
    applyStimulusRead(2'b11, 0, 32'h0000_3000, 32'h2222_0000);
    applyStimulusRead(2'b11, 1, 32'h0000_3000, 32'h2222_0001);
    applyStimulusRead(2'b11, 0, 32'h0000_3000, 32'h2222_0002);
    applyStimulusRead(2'b11, 1, 32'h0000_3000, 32'h2222_0003);

    mWValid[1] = 1'b1; mWData[1] = 32'h1234_5678; mWStrb[1] = 4'hF;
    sWReady = 1'b1; sAwReady = 1'b1;
    evalCycle();
    chk("wfirst_wready_c0", 32'(oWReady), 32'd0);
    chk("wfirst_swvalid_c0", 32'(sBus.Wvalid), 32'd0);
    advance();
    evalCycle();
    chk("wfirst_wready_c1", 32'(oWReady), 32'd0);
    advance();
    mAwValid[1] = 1'b1; mAwData[1] = 32'h0000_2000;
    evalCycle();
    chk("wfirst_awvalid_idle", 32'(sBus.AWvalid), 32'd0);
    chk("wfirst_wready_c2", 32'(oWReady), 32'd0);
    advance();
    evalCycle();
    chk("wr_s_awvalid", 32'(sBus.AWvalid), 32'd1);
    chk("wr_s_wvalid", 32'(sBus.Wvalid), 32'd1);
    chk("wr_s_awdata", sBus.AWdata, 32'h0000_2000);
    chk("wr_s_wdata", sBus.Wdata, 32'h1234_5678);
    chk("wr_s_wstrb", 32'(sBus.Wstrb), 32'hF);
    chk("wr_m1_wready", 32'(oWReady), 32'b10);
    advance();
    mAwValid = 2'b00; mWValid = 2'b00; sBValid = 1'b1; mBReady[1] = 1'b1;
    evalCycle();
    chk("wr_resp_awvalid_low", 32'(sBus.AWvalid), 32'd0);
    chk("wr_resp_wvalid_low", 32'(sBus.Wvalid), 32'd0);
    chk("wr_bvalid", 32'(oBValid), 32'b10);
    chk("wr_s_bready", 32'(sBus.Bready), 32'd1);
    advance();
    evalCycle();
    chk("wr_bvalid_pulse_end", 32'(oBValid), 32'd0);
    chk("wr_s_bready_end", 32'(sBus.Bready), 32'd0);
    advance();
    idleInputs();

    mArValid[0] = 1'b1; mArData[0] = 32'h0000_3000;
    mAwValid[1] = 1'b1; mAwData[1] = 32'h0000_4000;
    mWValid[1] = 1'b1; mWData[1] = 32'hCAFE_0001; mWStrb[1] = 4'h3;
    sArReady = 1'b1; sAwReady = 1'b1; sWReady = 1'b1;
    evalCycle();
    advance();
    evalCycle();
    chk("conc_s_arvalid", 32'(sBus.ARvalid), 32'd1);
    chk("conc_s_ardata", sBus.ARdata, 32'h0000_3000);
    chk("conc_s_awvalid", 32'(sBus.AWvalid), 32'd1);
    chk("conc_s_awdata", sBus.AWdata, 32'h0000_4000);
    chk("conc_s_wvalid", 32'(sBus.Wvalid), 32'd1);
    advance();
    mArValid = 2'b00; mAwValid = 2'b00; mWValid = 2'b00;
    sRValid = 1'b1; sRData = 32'h55AA_55AA; sBValid = 1'b1;
    mRReady[0] = 1'b1; mBReady[1] = 1'b1;
    evalCycle();
    chk("conc_rvalid", 32'(oRValid), 32'b01);
    chk("conc_bvalid", 32'(oBValid), 32'b10);
    advance();
    evalCycle();
    chk("idle_rvalid_ignored", 32'(oRValid), 32'd0);
    chk("idle_s_rready", 32'(sBus.Rready), 32'd0);
    chk("idle_bvalid_ignored", 32'(oBValid), 32'd0);
    advance();
    idleInputs();

    mArValid[0] = 1'b1; mArData[0] = 32'h0000_6000; sArReady = 1'b1;
    evalCycle();
    advance();
    evalCycle();
    advance();
    mArValid = 2'b00; sRValid = 1'b1; mRReady[0] = 1'b1; sRData = 32'h0BAD_0BAD;
    evalCycle();
    chk("abort_rvalid_before", 32'(oRValid), 32'b01);
    chk("abort_s_rready_before", 32'(sBus.Rready), 32'd1);
    rst = 1'b1;
    #1;
    modelReset();
    chk("abort_rvalid", 32'(oRValid), 32'd0);
    chk("abort_s_rready", 32'(sBus.Rready), 32'd0);
    chk("abort_s_ardata", sBus.ARdata, 32'h0);
    checkOutput();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idleInputs();
    applyStimulusRead(2'b10, 1, 32'h0000_5000, 32'h7777_0001);
    applyStimulusRead(2'b11, 0, 32'h0000_5000, 32'h7777_0002);

    applyReset();
    rdStart = rdDone;
    wrStart = wrDone;
    for (int n = 0; n < 3000; n++) begin
      applyStimulusRandom();
      evalCycle();
      advance();
    end
    chk("rand_read_progress", 32'((rdDone - rdStart) > 10), 32'd1);
    chk("rand_write_progress", 32'((wrDone - wrStart) > 10), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

Two-master to one-slave AXI4-Lite arbiter that shares the memory/peripheral slave port between the mriscvcore master (M0) and a second requester (M1, debug/DMA). It has independent read and write arbiters, each with round-robin priority and one outstanding transaction per direction. It sits between the masters' AXI4-Lite ports and the single slave port, and adds no payload buffering: address and data pass through combinationally once a grant is held.

## Interface
- No parameters; widths fixed: address 32, data 32, strobe 4, prot 3.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- mN_ARdata (N=0,1)  in  32  read address; mN_ARprot  in  3; mN_ARvalid  in  1; mN_ARready  out  1
- mN_Rdata  out  32  read data (broadcast of s_Rdata); mN_Rvalid  out  1; mN_Rready  in  1
- mN_AWdata  in  32  write address; mN_AWprot  in  3; mN_AWvalid  in  1; mN_AWready  out  1
- mN_Wdata  in  32; mN_Wstrb  in  4; mN_Wvalid  in  1; mN_Wready  out  1
- mN_Bvalid  out  1  write acknowledge; mN_Bready  in  1
- s_ARdata  out  32; s_ARprot  out  3; s_ARvalid  out  1; s_ARready  in  1
- s_Rdata  in  32; s_Rvalid  in  1; s_Rready  out  1
- s_AWdata  out  32; s_AWprot  out  3; s_AWvalid  out  1; s_AWready  in  1
- s_Wdata  out  32; s_Wstrb  out  4; s_Wvalid  out  1; s_Wready  in  1
- s_Bvalid  in  1; s_Bready  out  1

## Operation
- Read FSM: RD_IDLE, RD_ADDR, RD_DATA. Write FSM: WR_IDLE, WR_ADDR, WR_RESP. The two FSMs are fully independent; a read and a write may be granted to different masters at the same time.
- Each FSM has a registered grant `g` (0/1) and a priority pointer `p` (reset 0).
- IDLE arbitration:
  - Read requests are mN_ARvalid; write requests are mN_AWvalid.
  - Only one master requesting: grant it.
  - Both requesting: grant master `p`.
  - Move to RD_ADDR/WR_ADDR on the next edge.
- RD_ADDR:
  - s_AR* = granted m_AR*; s_ARvalid = mg_ARvalid; mg_ARready = s_ARready.
  - On AR handshake, go to RD_DATA.
- RD_DATA:
  - mg_Rvalid = s_Rvalid; s_Rready = mg_Rready.
  - On R handshake, go to RD_IDLE and set p <= ~g.
- WR_ADDR:
  - AW and W are forwarded from the granted master concurrently.
  - Flags aw_done and w_done latch the respective handshakes; once a channel's flag is set, its s_*valid and mg_*ready are forced to 0.
  - When both handshakes are complete (same cycle or different cycles), go to WR_RESP.
- WR_RESP:
  - mg_Bvalid = s_Bvalid; s_Bready = mg_Bready.
  - On B handshake, go to WR_IDLE, set p <= ~g and clear the flags.
- A master presenting Wvalid without AWvalid is not granted; its Wready stays 0.
- Non-granted masters and idle states: all ready/valid outputs toward that master are 0. mN_Rdata always equals s_Rdata.
- Slave payload outputs (s_ARdata, s_AWdata, s_Wdata, prot, strb) carry the granted master's values. In IDLE they are 0.

## Timing
- Reset, asynchronous: both FSMs go to IDLE, p=0, g=0, flags cleared.
  - All s_*valid, s_Rready and s_Bready are 0.
  - All mN_*ready, mN_Rvalid and mN_Bvalid are 0.
  - Payload outputs are 0.
- Arbitration latency: 1 cycle. A request sampled in IDLE at edge k gives s_ARvalid/s_AWvalid high in cycle k+1. Best-case address handshake is in cycle k+1.
- Best case: read in 3 cycles (IDLE, ADDR, DATA); write in 3 cycles. A back-to-back request from the other master is granted on the cycle after completion.
- Masters must hold valid and payload stable until their handshake. The grant never changes while the FSM is outside IDLE, even if the granted master deasserts valid.
- Simultaneous AW and W handshake in one cycle: go directly to WR_RESP.
- Slave asserting Bvalid/Rvalid while the FSM is in IDLE or ADDR: ignored. No ready is asserted, so the response is not consumed.
- Reset mid-transaction aborts immediately. No response is forwarded afterward.

## Test plan
- Single read from M0 only: ARdata=0x0000_1000, slave ARready=1, Rdata=0xDEAD_BEEF after 2 cycles.
  - Required: s_ARvalid in cycle 1; m0_Rvalid coincides with s_Rvalid; m0_Rdata=0xDEAD_BEEF; m1 sees no valid/ready; p=1 afterward.
- Both masters assert ARvalid at the same edge after reset.
  - Required: M0 granted first, M1 second.
  - Repeat with both requesting again: M0 granted after M1 (strict alternation over 4 transactions).
- Write with W before AW: M1 Wvalid at cycle 0, AWvalid at cycle 2 (0x2000, Wdata=0x1234_5678, Wstrb=0xF).
  - Required: m1_Wready=0 until grant; s_Wvalid asserts after grant; one s_Bready handshake; m1_Bvalid pulse of 1 cycle.
- Slave AWready=1 and Wready=1 in the same cycle.
  - Required: WR_RESP entered next cycle; s_AWvalid/s_Wvalid deassert.
- Concurrent read from M0 and write from M1.
  - Required: both proceed in parallel with no stalls; both complete in 3 cycles.
- rst asserted during RD_DATA with s_Rvalid=1.
  - Required: all outputs 0 in the same cycle; after release, the next request is granted normally.
